control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised hardwired control unit for the simple-CPU datapath. It replaces hand-stepped T0..Tn strobe sequences with a synchronous state machine. The machine runs instruction fetch and then executes the control-transfer class (jr, jal, conditional branch, nop, halt), with a memory-ready handshake on fetch. It drives the datapath's existing bus/register strobes directly and reads IR opcode and CON_out back from the datapath.

## Interface
Parameters:
- IR_W, 32, instruction register width
- OPC_W, 5, opcode width; opcode = IR[IR_W-1 -: OPC_W]
- OP_W, 5, ALU `operation` width
- MEM_TIMEOUT, 15, max T1 wait cycles; used only with the timeout macro

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- IR  in  IR_W  datapath IR contents
- CON_out  in  1  branch condition from CON FF
- MemReady  in  1  memory read data valid
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin, Rin  out  1 each  register load strobes
- IncPC, Read, CON_in  out  1 each  PC increment, memory read, CON FF load
- Gra, Grb, Rout, LinkSel  out  1 each  IR register-select controls; LinkSel forces R15 as the Rin target
- operation  out  OP_W  ALU op
- Run  out  1  high while executing
- Fault  out  1  sticky fault flag

## Operation
- Outputs are decoded from the registered state only. The single exception is T6 PCin, which equals CON_out.
- Strobes not listed for a state are 0. `operation` is 0 except in T5.
- States and the strobes asserted in each:
  - RST: entered while Reset=1; all outputs 0, Run=0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin (first cycle only), Read, MDRin. Stays in T1 until MemReady=1.
  - T2: MDRout, IRin.
  - T3: dispatch on the opcode latched in T2.
- Opcodes (5-bit): jr=10011, jal=10100, br=10010, nop=11010, halt=11011.
- jr:
  - T3: Gra, Rout, PCin.
  - Then T0.
- jal:
  - T3: PCout, Rin, LinkSel.
  - T4: Gra, Rout, PCin.
  - Then T0.
- br:
  - T3: Gra, Rout, CON_in.
  - T4: PCout, Yin.
  - T5: Cout, Zin, operation=ALU_ADD (00011).
  - T6: Zlowout, PCin=CON_out.
  - Then T0.
- nop: T3 drives nothing, then T0.
- halt: T3 goes to HALT. In HALT, Run=0, all strobes 0, and the machine stays until Reset.
- Any other opcode: FAULT. In FAULT, Fault=1, Run=0, all strobes 0, and the machine stays until Reset.
- Run=1 in T0..T6. Run=0 in RST, HALT and FAULT.

## Timing
- Reset: on the Clock edge with Reset=1, the state becomes RST. Every output is 0 and Fault clears.
- First T0 is the cycle after Reset deasserts.
- Reset mid-instruction aborts on that edge. A partial PC increment is allowed; no further strobes are driven.
- Fetch latency is 3 cycles plus W wait cycles, where W is the number of T1 cycles with MemReady=0.
- PCin is asserted only in the first T1 cycle, so PC does not re-increment during waits.
- Instruction latency with W=0: jr 4, jal 5, br 7, nop 4 cycles (T0 to the next T0).
- MemReady is ignored outside T1.
- IR is sampled at the end of T2. IR changes after T2 do not affect dispatch.
- CON_out is sampled combinationally in T6 only.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - A wait counter (width $clog2(MEM_TIMEOUT+1)) counts consecutive T1 cycles with MemReady=0.
  - On reaching MEM_TIMEOUT, the next state is FAULT.
  - The counter clears on T1 exit and on Reset.
- SEQ_MEM_TIMEOUT_EN undefined: T1 waits indefinitely, and no counter logic is present.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state enum (RST, T0..T6, HALT, FAULT)
  - the opcode localparams (OPC_JR, OPC_JAL, OPC_BR, OPC_NOP, OPC_HALT)
  - ALU_ADD
- Sub-module control_decode: combinational opcode → instruction-class one-hot (jr/jal/br/nop/halt/illegal). It is instantiated once and registered at T2.
- The top-level module holds the state register, the optional wait counter and the output decode.

## Test plan
- Reset, then jr: hold Reset 2 cycles, then release with IR=0x98800000 and MemReady=1.
  - Expect T0, T1, T2, T3 with exact strobes; Gra/Rout/PCin only in T3.
  - Expect next T0 at cycle 5.
  - During reset all outputs are 0 and Run=0.
- jal: IR=0xA0800000.
  - Expect T3 to assert PCout/Rin/LinkSel and T4 to assert Gra/Rout/PCin.
  - Expect 5-cycle period.
- br taken and not taken: IR=0x90800000.
  - With CON_out=1: T6 PCin=1 and T5 operation=00011.
  - With CON_out=0: T6 PCin=0.
  - Both paths return to T0.
- Memory wait: drive MemReady=0 for 3 cycles in T1.
  - T1 lasts 4 cycles; PCin is high only in the first; Read/MDRin are held throughout.
- Halt, illegal and reset: halt=0xD8000000 leads to HALT with Run=0, holding 10 cycles. Opcode 11111 leads to FAULT=1. Reset asserted during br T4 gives all outputs 0 on the next edge.
- Timeout with SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=4: hold MemReady=0 and expect FAULT after 4 wait cycles. With the macro undefined, there is still no fault after 100 cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// States, opcode values and the ALU add code used by the branch path.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        RST,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALT,
        FAULT
    } state_t;

    typedef struct packed {
        logic jr;
        logic jal;
        logic br;
        logic nop;
        logic halt;
        logic illegal;
    } cls_t;

    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_JAL  = 5'b10100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD  = 5'b00011;

endpackage

// File: rtl/control_decode.sv
// Opcode to instruction-class one-hot decoder.
// Anything not in the control-transfer class is flagged illegal.
module control_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
)
(
    input  logic [OPC_W-1:0] opc,
    output cls_t             cls
);

    // Exactly one class bit is set for every opcode value.
    always_comb begin
        cls = '0;
        if (opc == OPC_W'(OPC_JR))
            cls.jr = 1'b1;
        else if (opc == OPC_W'(OPC_JAL))
            cls.jal = 1'b1;
        else if (opc == OPC_W'(OPC_BR))
            cls.br = 1'b1;
        else if (opc == OPC_W'(OPC_NOP))
            cls.nop = 1'b1;
        else if (opc == OPC_W'(OPC_HALT))
            cls.halt = 1'b1;
        else
            cls.illegal = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the simple-CPU datapath.
// Define SEQ_MEM_TIMEOUT_EN to fault on a stalled memory read.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OPC_W       = 5,
    parameter int OP_W        = 5,
    parameter int MEM_TIMEOUT = 15
)
(
    input  logic            Clock,
    input  logic            Reset,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_out,
    input  logic            MemReady,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Cout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Rin,
    output logic            IncPC,
    output logic            Read,
    output logic            CON_in,
    output logic            Gra,
    output logic            Grb,
    output logic            Rout,
    output logic            LinkSel,
    output logic [OP_W-1:0] operation,
    output logic            Run,
    output logic            Fault
);

    state_t state, state_n;
    cls_t   cls, cls_q;
    logic   t1_first;
    logic   mem_to;
    logic [IR_W-OPC_W-1:0] unused_ir;

    assign unused_ir = IR[IR_W-OPC_W-1:0];

    control_decode #(.OPC_W(OPC_W)) u_dec (
        .opc (IR[IR_W-1 -: OPC_W]),
        .cls (cls)
    );

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Count consecutive stalled T1 cycles; any T1 exit clears it.
    always_ff @(posedge Clock) begin
        if (Reset || state != T1 || MemReady)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign mem_to = (state == T1) && !MemReady &&
                    (wait_cnt == CW'(MEM_TIMEOUT - 1));
`else
    logic [31:0] unused_mem_timeout;
    assign unused_mem_timeout = 32'(MEM_TIMEOUT);
    assign mem_to = 1'b0;
`endif

    // State register, first-T1 flag and class latched at end of T2.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= RST;
            t1_first <= 1'b0;
            cls_q    <= '0;
        end else begin
            state    <= state_n;
            t1_first <= (state == T0);
            if (state == T2)
                cls_q <= cls;
        end
    end

    // Next-state logic and strobe decode from the registered state.
    always_comb begin
        state_n   = state;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        Cout      = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Rin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        CON_in    = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Rout      = 1'b0;
        LinkSel   = 1'b0;
        operation = '0;
        Run       = 1'b0;
        Fault     = 1'b0;
        unique case (state)
            RST: state_n = T0;
            T0: begin
                Run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_n = T1;
            end
            T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = t1_first;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_to)
                    state_n = FAULT;
                else if (MemReady)
                    state_n = T2;
            end
            T2: begin
                Run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_n = T3;
            end
            T3: begin
                Run = 1'b1;
                unique case (1'b1)
                    cls_q.jr: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        PCin    = 1'b1;
                        state_n = T0;
                    end
                    cls_q.jal: begin
                        PCout   = 1'b1;
                        Rin     = 1'b1;
                        LinkSel = 1'b1;
                        state_n = T4;
                    end
                    cls_q.br: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        CON_in  = 1'b1;
                        state_n = T4;
                    end
                    cls_q.nop:     state_n = T0;
                    cls_q.halt:    state_n = HALT;
                    cls_q.illegal: state_n = FAULT;
                    default:       state_n = FAULT;
                endcase
            end
            T4: begin
                Run = 1'b1;
                if (cls_q.jal) begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    PCin    = 1'b1;
                    state_n = T0;
                end else begin
                    PCout   = 1'b1;
                    Yin     = 1'b1;
                    state_n = T5;
                end
            end
            T5: begin
                Run       = 1'b1;
                Cout      = 1'b1;
                Zin       = 1'b1;
                operation = OP_W'(ALU_ADD);
                state_n   = T6;
            end
            T6: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = CON_out;
                state_n = T0;
            end
            HALT:    state_n = HALT;
            FAULT: begin
                Fault   = 1'b1;
                state_n = FAULT;
            end
            default: state_n = FAULT;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Expected strobe vectors per cycle are hand-written tables.
module tb_control_sequencer;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        CON_out;
    logic        MemReady;
    logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin;
    logic Yin, Zin, Rin, IncPC, Read, CON_in, Gra, Grb, Rout, LinkSel;
    logic [4:0] operation;
    logic Run, Fault;

    int checks = 0;
    int errors = 0;

    localparam logic [24:0] B_PCOUT   = 25'(1) << 24;
    localparam logic [24:0] B_ZLOW    = 25'(1) << 23;
    localparam logic [24:0] B_MDROUT  = 25'(1) << 22;
    localparam logic [24:0] B_COUT    = 25'(1) << 21;
    localparam logic [24:0] B_MARIN   = 25'(1) << 20;
    localparam logic [24:0] B_PCIN    = 25'(1) << 19;
    localparam logic [24:0] B_MDRIN   = 25'(1) << 18;
    localparam logic [24:0] B_IRIN    = 25'(1) << 17;
    localparam logic [24:0] B_YIN     = 25'(1) << 16;
    localparam logic [24:0] B_ZIN     = 25'(1) << 15;
    localparam logic [24:0] B_RIN     = 25'(1) << 14;
    localparam logic [24:0] B_INCPC   = 25'(1) << 13;
    localparam logic [24:0] B_READ    = 25'(1) << 12;
    localparam logic [24:0] B_CONIN   = 25'(1) << 11;
    localparam logic [24:0] B_GRA     = 25'(1) << 10;
    localparam logic [24:0] B_GRB     = 25'(1) << 9;
    localparam logic [24:0] B_ROUT    = 25'(1) << 8;
    localparam logic [24:0] B_LINK    = 25'(1) << 7;
    localparam logic [24:0] B_RUN     = 25'(1) << 6;
    localparam logic [24:0] B_FAULT   = 25'(1) << 5;

    localparam logic [24:0] V_ZERO = 25'd0;
    localparam logic [24:0] V_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [24:0] V_T1F  = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] V_T1W  = B_ZLOW | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] V_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [24:0] V_JR3  = B_GRA | B_ROUT | B_PCIN | B_RUN;
    localparam logic [24:0] V_JAL3 = B_PCOUT | B_RIN | B_LINK | B_RUN;
    localparam logic [24:0] V_BR3  = B_GRA | B_ROUT | B_CONIN | B_RUN;
    localparam logic [24:0] V_BR4  = B_PCOUT | B_YIN | B_RUN;
    localparam logic [24:0] V_BR5  = B_COUT | B_ZIN | B_RUN | 25'd3;
    localparam logic [24:0] V_BR6T = B_ZLOW | B_PCIN | B_RUN;
    localparam logic [24:0] V_BR6N = B_ZLOW | B_RUN;
    localparam logic [24:0] V_IDLE = B_RUN;
    localparam logic [24:0] V_FLT  = B_FAULT;

    localparam logic [31:0] IR_JR   = 32'h9880_0000;
    localparam logic [31:0] IR_JAL  = 32'hA080_0000;
    localparam logic [31:0] IR_BR   = 32'h9080_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    logic [24:0] obs;
    logic [24:0] ev [0:15];

    assign obs = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin,
                  IRin, Yin, Zin, Rin, IncPC, Read, CON_in, Gra, Grb,
                  Rout, LinkSel, Run, Fault, operation};

    control_sequencer #(
        .IR_W(32), .OPC_W(5), .OP_W(5), .MEM_TIMEOUT(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_out(CON_out),
        .MemReady(MemReady),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Rin(Rin), .IncPC(IncPC), .Read(Read),
        .CON_in(CON_in), .Gra(Gra), .Grb(Grb), .Rout(Rout),
        .LinkSel(LinkSel), .operation(operation), .Run(Run),
        .Fault(Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        Reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clock);
            checks++;
            if (obs !== V_ZERO) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h", c, obs, V_ZERO);
            end
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (obs !== V_T0) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs, V_T0);
        end
    endtask

    task automatic test_jr();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2;
        ev[3] = V_JR3; ev[4] = V_T0;
        IR = IR_JR;
        MemReady = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 3) IR = IR_ILL;
            if (c == 4) IR = IR_JR;
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL jr cyc %0d got %h want %h", c, obs, ev[c]);
            end
            if (c < 4) @(negedge Clock);
        end
    endtask

    task automatic test_jal();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2;
        ev[3] = V_JAL3; ev[4] = V_JR3; ev[5] = V_T0;
        IR = IR_JAL;
        for (int c = 0; c <= 5; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL jal cyc %0d got %h want %h", c, obs, ev[c]);
            end
            if (c < 5) @(negedge Clock);
        end
    endtask

    task automatic test_br(input logic con);
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2; ev[3] = V_BR3;
        ev[4] = V_BR4; ev[5] = V_BR5;
        ev[6] = con ? V_BR6T : V_BR6N; ev[7] = V_T0;
        IR = IR_BR;
        CON_out = con;
        for (int c = 0; c <= 7; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL br con=%0b cyc %0d got %h want %h",
                         con, c, obs, ev[c]);
            end
            if (c < 7) @(negedge Clock);
        end
        CON_out = 1'b0;
    endtask

    task automatic test_mem_wait();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T1W; ev[3] = V_T1W;
        ev[4] = V_T1W; ev[5] = V_T2; ev[6] = V_IDLE; ev[7] = V_T0;
        IR = IR_NOP;
        MemReady = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            if (c == 4) MemReady = 1'b1;
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL mem_wait cyc %0d got %h want %h",
                         c, obs, ev[c]);
            end
            if (c < 7) @(negedge Clock);
        end
    endtask

    task automatic test_timeout();
        IR = IR_NOP;
        MemReady = 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T1W; ev[3] = V_T1W;
        ev[4] = V_T1W; ev[5] = V_FLT; ev[6] = V_FLT;
        for (int c = 0; c <= 6; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h want %h",
                         c, obs, ev[c]);
            end
            if (c < 6) @(negedge Clock);
        end
        MemReady = 1'b1;
        test_reset();
`else
        for (int c = 0; c < 101; c++) @(negedge Clock);
        checks++;
        if (obs !== V_T1W) begin
            errors++;
            $display("FAIL no_timeout got %h want %h", obs, V_T1W);
        end
        MemReady = 1'b1;
        ev[0] = V_T2; ev[1] = V_IDLE; ev[2] = V_T0;
        for (int c = 0; c <= 2; c++) begin
            @(negedge Clock);
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL no_timeout_exit cyc %0d got %h want %h",
                         c, obs, ev[c]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2; ev[3] = V_BR3;
        ev[4] = V_BR4; ev[5] = V_ZERO; ev[6] = V_T0;
        IR = IR_BR;
        for (int c = 0; c <= 6; c++) begin
            if (c == 5) Reset = 1'b1;
            if (c == 6) Reset = 1'b0;
            if (c >= 5) @(negedge Clock);
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %h want %h",
                         c, obs, ev[c]);
            end
            if (c < 4) @(negedge Clock);
        end
    endtask

    task automatic test_halt();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2; ev[3] = V_IDLE;
        IR = IR_HALT;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (obs !== ((c < 4) ? ev[c] : V_ZERO)) begin
                errors++;
                $display("FAIL halt cyc %0d got %h want %h", c, obs,
                         (c < 4) ? ev[c] : V_ZERO);
            end
            @(negedge Clock);
        end
        test_reset();
    endtask

    task automatic test_illegal();
        ev[0] = V_T0; ev[1] = V_T1F; ev[2] = V_T2; ev[3] = V_IDLE;
        ev[4] = V_FLT; ev[5] = V_FLT; ev[6] = V_FLT;
        IR = IR_ILL;
        for (int c = 0; c <= 6; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h want %h",
                         c, obs, ev[c]);
            end
            if (c < 6) @(negedge Clock);
        end
        IR = IR_NOP;
        test_reset();
    endtask

    initial begin
        Reset    = 1'b1;
        IR       = 32'd0;
        CON_out  = 1'b0;
        MemReady = 1'b1;
        test_reset();
        test_jr();
        test_jal();
        test_br(1'b1);
        test_br(1'b0);
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_halt();
        test_illegal();
        test_jr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
